// File: rtl/ecc_encode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ecc_encode_pipe
// Description : Multi-lane extended-Hamming (SECDED) encoder behind an
//               elastic valid/ready pipeline of NumStages register stages.
//               Optional macro ECC_ENCODE_PIPE_INJECT_EN adds error injection.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_encode_pipe #(
    parameter int DataWidth = 64,
    parameter int NumLanes  = 1,
    parameter int NumStages = 1,
    // Smallest p with 2**p >= DataWidth+p+1, over the legal range 4..120
    localparam int ParityWidth   = (DataWidth <= 4)  ? 3 :
                                   (DataWidth <= 11) ? 4 :
                                   (DataWidth <= 26) ? 5 :
                                   (DataWidth <= 57) ? 6 : 7,
    localparam int CodeWordWidth = DataWidth + ParityWidth,
    localparam int c_IDX_W       = $clog2(CodeWordWidth + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [NumLanes*DataWidth-1:0]          data_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [NumLanes*(CodeWordWidth+1)-1:0]  data_o,
`ifdef ECC_ENCODE_PIPE_INJECT_EN
    input  logic                                   inject_i,
    input  logic [c_IDX_W-1:0]                     inject_idx_i,
`endif
    output logic [31:0]                            count_o
);

    localparam int c_LANE_W = CodeWordWidth + 1;
    localparam int c_OUT_W  = NumLanes * c_LANE_W;

    function automatic logic [c_LANE_W-1:0] f_encode(input logic [DataWidth-1:0] d);
        logic [c_LANE_W-1:0] cw;
        int                  k;
        logic                p;
        cw = '0;
        k  = 0;
        for (int j = 1; j <= CodeWordWidth; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j-1] = d[k];
                k++;
            end
        end
        // Parity slots are still zero here, so XOR over every position is safe
        for (int i = 0; i < ParityWidth; i++) begin
            p = 1'b0;
            for (int j = 1; j <= CodeWordWidth; j++) begin
                if (((j >> i) & 1) == 1) p = p ^ cw[j-1];
            end
            cw[(1 << i) - 1] = p;
        end
        cw[CodeWordWidth] = ^cw[CodeWordWidth-1:0];
        return cw;
    endfunction

    logic [c_LANE_W-1:0]  w_flip;
    logic [c_OUT_W-1:0]   w_enc;
    logic [NumStages-1:0] w_free;
    logic [NumStages-1:0] w_leave;
    logic [NumStages-1:0] w_in_vld;
    logic [c_OUT_W-1:0]   w_in_data [NumStages];
    logic [NumStages-1:0] r_vld;
    logic [c_OUT_W-1:0]   r_data    [NumStages];
    logic [31:0]          r_count;

`ifdef ECC_ENCODE_PIPE_INJECT_EN
    always_comb begin
        w_flip = '0;
        if (inject_i && (int'(inject_idx_i) <= CodeWordWidth)) begin
            w_flip[inject_idx_i] = 1'b1;
        end
    end
`else
    assign w_flip = '0;
`endif

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        assign w_enc[k*c_LANE_W +: c_LANE_W] =
            f_encode(data_i[k*DataWidth +: DataWidth]) ^ w_flip;
    end

    for (genvar s = 0; s < NumStages; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_in_vld[s]  = valid_i;
            assign w_in_data[s] = w_enc;
        end else begin : g_body
            assign w_in_vld[s]  = r_vld[s-1];
            assign w_in_data[s] = r_data[s-1];
        end
    end

    // Back-pressure ripples from the output towards stage 0 in one cycle
    always_comb begin
        logic w_chain;
        w_chain = ready_i;
        w_free  = '0;
        w_leave = '0;
        for (int s = NumStages - 1; s >= 0; s--) begin
            w_leave[s] = r_vld[s] & w_chain;
            w_chain    = ~r_vld[s] | w_leave[s];
            w_free[s]  = w_chain;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld   <= '0;
            r_count <= '0;
            for (int s = 0; s < NumStages; s++) r_data[s] <= '0;
        end else begin
            for (int s = 0; s < NumStages; s++) begin
                if (w_free[s]) begin
                    r_vld[s] <= w_in_vld[s];
                    if (w_in_vld[s]) r_data[s] <= w_in_data[s];
                end
            end
            if (w_leave[NumStages-1]) r_count <= r_count + 32'd1;
        end
    end

    assign ready_o = w_free[0];
    assign valid_o = r_vld[NumStages-1];
    assign data_o  = r_data[NumStages-1];
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ecc_encode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_encode_pipe
// Description : Scoreboard bench for ecc_encode_pipe (64-bit data, 2 lanes,
//               3 stages) against a syndrome-style Hamming reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_encode_pipe;

    localparam int DW = 64;
    localparam int NL = 2;
    localparam int NS = 3;

    function automatic int f_pw(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int PW = f_pw(DW);
    localparam int CW = DW + PW;
    localparam int LW = CW + 1;
    localparam int IW = NL * DW;
    localparam int OW = NL * LW;
    localparam int XW = $clog2(CW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [IW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [OW-1:0] data_o;
    logic [31:0]   count_o;
    logic          inj_b;
    logic [7:0]    idx_b;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rdy_mode = 1;
    bit            lat_chk = 1'b0;
    int            m_count = 0;

    logic [OW-1:0] exp_q[$];
    int            cyc_q[$];
    bit            lat_q[$];

    ecc_encode_pipe #(
        .DataWidth (DW),
        .NumLanes  (NL),
        .NumStages (NS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
`ifdef ECC_ENCODE_PIPE_INJECT_EN
        .inject_i     (inj_b),
        .inject_idx_i (idx_b[XW-1:0]),
`endif
        .count_o      (count_o)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Each data bit k goes to the k-th non-power-of-two position; the XOR of
    // the positions of all set data bits is exactly the parity pattern.
    function automatic logic [LW-1:0] f_ref_lane(input logic [DW-1:0] d, input bit inj, input int idx);
        logic [LW-1:0] cw;
        int            pos;
        int            syn;
        cw  = '0;
        pos = 0;
        syn = 0;
        for (int k = 0; k < DW; k++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
            if (d[k]) begin
                cw[pos-1] = 1'b1;
                syn = syn ^ pos;
            end
        end
        for (int i = 0; i < PW; i++) cw[(1 << i) - 1] = syn[i];
        cw[CW] = ($countones(cw[CW-1:0]) % 2) == 1;
        if (inj && idx <= CW) cw[idx] = ~cw[idx];
        return cw;
    endfunction

    function automatic logic [OW-1:0] f_ref(input logic [IW-1:0] d, input bit inj, input int idx);
        logic [OW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*LW +: LW] = f_ref_lane(d[k*DW +: DW], inj, idx);
        return r;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0)      ready_i = 1'b0;
        else if (rdy_mode == 1) ready_i = 1'b1;
        else                    ready_i = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard push on every accepted input word
    initial forever begin
        @(negedge clk);
        if (!rst && valid_i && ready_o) begin
            exp_q.push_back(f_ref(data_i, inj_b, int'(idx_b)));
            cyc_q.push_back(cyc);
            lat_q.push_back(lat_chk);
        end
    end

    // Monitor: pops on every output transfer, also checks count and stalls
    initial begin
        bit            hold;
        logic [OW-1:0] held;
        logic [OW-1:0] e;
        int            c;
        bit            l;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold    = 1'b0;
                m_count = 0;
            end else begin
                if (hold) chk("stall_hold", {valid_o, data_o}, {1'b1, held});
                hold = 1'b0;
                chk("count", count_o, m_count);
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        c = cyc_q.pop_front();
                        l = lat_q.pop_front();
                        chk("data", data_o, e);
                        if (l && lat_chk) chk("latency", cyc - c, NS);
                    end
                    m_count++;
                end else if (valid_o) begin
                    hold = 1'b1;
                    held = data_o;
                end
            end
        end
    end

    task automatic send(input logic [IW-1:0] d);
        int n;
        n       = 0;
        valid_i = 1'b1;
        data_i  = d;
        @(negedge clk);
        while (!ready_o) begin
            if (n >= 300) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    function automatic logic [IW-1:0] f_rand();
        logic [IW-1:0] r;
        for (int k = 0; k < IW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int acc;
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        inj_b   = 1'b0;
        idx_b   = '0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_count", count_o, 0);
        chk("rst_data", data_o, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", ready_o, 1'b1);
        @(posedge clk);
        #1;

        // Zero word and lane-1 single-bit word
        lat_chk = 1'b1;
        send('0);
        send({64'h1, 64'h0});
        repeat (2) @(posedge clk);
        #1;
        chk("lane_valid", valid_o, 1'b1);
        chk("lane0_zero", data_o[LW-1:0], 0);
        chk("lane1_ext_parity", data_o[2*LW-1], 1'b1);
        chk("lane1_nonzero", (data_o[2*LW-2:LW] != 0), 1'b1);

        // Back-to-back burst at full throughput
        for (int i = 0; i < 10; i++) send(f_rand());
        drain();
        chk("count_burst", count_o, 12);
        lat_chk = 1'b0;

        // Stall: only NS words fit while downstream is blocked
        rdy_mode = 0;
        @(posedge clk);
        #2;
        acc     = 0;
        valid_i = 1'b1;
        data_i  = f_rand();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready_o) begin
                acc++;
                @(posedge clk);
                #2;
                data_i = f_rand();
            end else begin
                @(posedge clk);
                #2;
            end
        end
        valid_i = 1'b0;
        chk("stall_accepts", acc, NS);
        chk("stall_ready_low", ready_o, 1'b0);
        rdy_mode = 1;
        @(posedge clk);
        #1;
        drain();

        // Random traffic with random back-pressure (and injection when built in)
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
`ifdef ECC_ENCODE_PIPE_INJECT_EN
            inj_b = ($urandom_range(0, 2) == 0);
            idx_b = 8'($urandom_range(0, (1 << XW) - 1));
`endif
            send(f_rand());
        end
        inj_b    = 1'b0;
        rdy_mode = 1;
        drain();

        // Asynchronous reset with words in flight
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(f_rand());
        send(f_rand());
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", valid_o, 1'b0);
        chk("async_rst_count", count_o, 0);
        chk("async_rst_data", data_o, 0);
        exp_q.delete();
        cyc_q.delete();
        lat_q.delete();
        @(posedge clk);
        #3;
        rst      = 1'b0;
        rdy_mode = 1;
        #1;
        chk("ready_after_async_rst", ready_o, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_word", valid_o, 1'b0);
        for (int i = 0; i < 5; i++) send(f_rand());
        drain();
        chk("count_after_rst", count_o, 5);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
